m68k_ram_ctrl: RTL

M68K_RAM_CTRL -- requirements
Module: m68k_ram_ctrl

---
 rtl/m68k_ram_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/m68k_ram_ctrl.sv
// m68k_ram_ctrl: bridges a 68000 async bus cycle to a synchronous single-port RAM, one RAM access per cycle.
// Latency: dtack low 2+WAIT_STATES clk after the request edge (+2 with M68K_RAM_CTRL_SYNC_INPUTS_EN defined).
// Backpressure: the CPU is stalled by withholding cpu_dtack_n; dtack is held until cpu_as_n is seen high.
module m68k_ram_ctrl #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     cpu_as_n,
    input  logic                     cpu_uds_n,
    input  logic                     cpu_lds_n,
    input  logic                     cpu_rw,
    input  logic [ADDRESS_WIDTH-1:1] cpu_addr,
    input  logic [15:0]              cpu_dout,
    output logic [15:0]              cpu_din,
    output logic                     cpu_dtack_n,
    output logic                     ram_we,
    output logic [1:0]               ram_mask,
    output logic [ADDRESS_WIDTH-1:1] ram_addr,
    output logic [15:0]              ram_din,
    input  logic [15:0]              ram_dout
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        CAPTURE,
        ACK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       as_n;
    logic       uds_n;
    logic       lds_n;
    logic       req;
    logic       accept;
    logic       rw_q;
    logic       we_nxt;
    logic       dtack_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;

`ifdef M68K_RAM_CTRL_SYNC_INPUTS_EN
    // Strobes come straight off the CPU bus; resolve metastability before the FSM looks at them.
    logic [1:0] as_sync;
    logic [1:0] uds_sync;
    logic [1:0] lds_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0], cpu_as_n};
            uds_sync <= {uds_sync[0], cpu_uds_n};
            lds_sync <= {lds_sync[0], cpu_lds_n};
        end
    end

    assign as_n  = as_sync[1];
    assign uds_n = uds_sync[1];
    assign lds_n = lds_sync[1];
`else
    assign as_n  = cpu_as_n;
    assign uds_n = cpu_uds_n;
    assign lds_n = cpu_lds_n;
`endif

    assign req = cs & ~as_n & (~uds_n | ~lds_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        dtack_nxt    = cpu_dtack_n;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // A cycle abandoned by the CPU still completes its RAM access but is never acknowledged.
                if (!as_n) begin
                    dtack_nxt = 1'b0;
                    state_nxt = ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                if (as_n) begin
                    dtack_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // On a zero-wait accept rw_q is not yet loaded, so take direction straight from the bus.
    assign we_nxt = (state_nxt == ACCESS) & ~(accept ? cpu_rw : rw_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 4'd0;
            ram_we      <= 1'b0;
            cpu_dtack_n <= 1'b1;
            ram_addr    <= '0;
            ram_din     <= 16'h0000;
            ram_mask    <= 2'b00;
            rw_q        <= 1'b1;
            cpu_din     <= 16'h0000;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            ram_we      <= we_nxt;
            cpu_dtack_n <= dtack_nxt;
            if (accept) begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_dout;
                ram_mask <= {~uds_n, ~lds_n};
                rw_q     <= cpu_rw;
            end
            if ((state == CAPTURE) && rw_q) begin
                cpu_din <= ram_dout;
            end
        end
    end

endmodule
